// File: rtl/round_robin_demux_pkg.sv
// Shared helpers for round_robin_demux: pointer width, wrapped increment and
// the cyclic first-free search used by the work-conserving build.
package round_robin_demux_pkg;

  localparam int MAX_N = 32;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  // First set bit of free[0..n-1], scanning cyclically from start; returns start if none.
  function automatic int first_free(input logic [MAX_N-1:0] free, input int start, input int n);
    int   idx;
    logic found;
    first_free = start;
    found      = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (!found && free[idx]) begin
          first_free = idx;
          found      = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/round_robin_demux_slot.sv
// One-entry valid/ready output register of round_robin_demux.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             drain_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] buf_q, buf_d;

  // A fill wins over a drain in the same cycle so the slot sustains one word per cycle.
  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    if (fill) begin
      full_d = 1'b1;
      buf_d  = fill_data;
    end else if (full_q && drain_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

  assign full = full_q;
  assign data = buf_q;

endmodule

// File: rtl/round_robin_demux.sv
// Streaming 1-to-N round-robin demultiplexer with a registered slot per channel.
// Define ROUND_ROBIN_DEMUX_SKIP_EN for work-conserving steering past stuck channels.
module round_robin_demux
  import round_robin_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  output logic [N-1:0]       down_valid,
  input  logic [N-1:0]       down_ready,
  output logic [N*WIDTH-1:0] down_data
);

  localparam int PW = ptr_w(N);

  logic [PW-1:0] ptr_q, ptr_d, tgt;
  logic [N-1:0]  full, free, fill;
  logic          xfer;

  // Handshake: a word moves on any edge where valid and ready are both high;
  // up_ready may follow down_ready combinationally, down_valid is pure flop output.
  assign free = ~full | down_ready;

`ifdef ROUND_ROBIN_DEMUX_SKIP_EN
  assign tgt      = PW'(first_free(MAX_N'(free), int'(ptr_q), N));
  assign up_ready = |free;
`else
  assign tgt      = ptr_q;
  assign up_ready = free[ptr_q];
`endif

  assign xfer = up_valid && up_ready;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign fill[g] = xfer && (tgt == PW'(g));
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .fill        (fill[g]),
      .fill_data   (up_data),
      .drain_ready (down_ready[g]),
      .full        (full[g]),
      .data        (down_data[g*WIDTH +: WIDTH])
    );
  end

  assign down_valid = full;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = PW'(next_idx(int'(tgt), N));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_round_robin_demux.sv
// Directed bench for round_robin_demux (WIDTH=8, N=4) with per-channel expected queues.
module tb_round_robin_demux;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           up_valid;
  logic           up_ready;
  logic [W-1:0]   up_data;
  logic [N-1:0]   down_valid;
  logic [N-1:0]   down_ready;
  logic [N*W-1:0] down_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[N][$];
  logic [N-1:0] m_full = '0;
  logic [1:0]   m_ptr  = '0;

  always #5 clk = ~clk;

  round_robin_demux #(.WIDTH(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] rdy);
    up_valid   = v;
    up_data    = d;
    down_ready = rdy;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic [N-1:0] free, nfull;
    logic         m_rdy, xfer;
    int           tgt;
    @(negedge clk);
    free = ~m_full | down_ready;
`ifdef ROUND_ROBIN_DEMUX_SKIP_EN
    m_rdy = |free;
    tgt   = m_ptr;
    for (int k = N - 1; k >= 0; k--)
      if (free[(int'(m_ptr) + k) % N]) tgt = (int'(m_ptr) + k) % N;
`else
    m_rdy = free[m_ptr];
    tgt   = m_ptr;
`endif
    if (!rst) begin
      chk("up_ready", up_ready, m_rdy);
      chk("down_valid", down_valid, m_full);
      chk("ptr", dut.ptr_q, m_ptr);
      for (int i = 0; i < N; i++)
        if (m_full[i]) chk($sformatf("down_data[%0d]", i), down_data[i*W +: W], exp_q[i][0]);
    end
    xfer  = up_valid && m_rdy && !rst;
    nfull = m_full;
    if (rst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      nfull = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_full[i] && down_ready[i]) begin
          void'(exp_q[i].pop_front());
          nfull[i] = 1'b0;
        end
      if (xfer) begin
        exp_q[tgt].push_back(up_data);
        nfull[tgt] = 1'b1;
      end
    end
    @(posedge clk);
    m_full = nfull;
    if (rst)       m_ptr = '0;
    else if (xfer) m_ptr = (tgt == N - 1) ? 2'd0 : 2'(tgt + 1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0);

    // Reset values
    do_reset();
    chk("rst_valid", down_valid, 4'b0000);
    chk("rst_data", down_data, '0);
    chk("rst_ready", up_ready, 1'b1);
    chk("rst_ptr", dut.ptr_q, 2'd0);

    // Fill all four channels with no consumer activity, then stall
    drive(1'b1, 8'h11, 4'b0000); cycle();
    drive(1'b1, 8'h22, 4'b0000); cycle();
    drive(1'b1, 8'h33, 4'b0000); cycle();
    drive(1'b1, 8'h44, 4'b0000); cycle();
    chk("full_valid", down_valid, 4'b1111);
    chk("full_data", down_data, 32'h44332211);
    drive(1'b1, 8'h55, 4'b0000);
    chk("full_stall", up_ready, 1'b0);
    cycle();

    // Same-cycle drain and refill of channel 0, pointer wraps to 1
    drive(1'b1, 8'h55, 4'b0001); cycle();
    chk("refill_valid", down_valid, 4'b1111);
    chk("refill_data0", down_data[7:0], 8'h55);
    chk("refill_ptr", dut.ptr_q, 2'd1);
    drive(1'b0, '0, 4'b1111); cycle();

    // Continuous drain: twelve words, one per cycle
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 8'(k), 4'b1111);
      chk("stream_no_stall", up_ready, 1'b1);
      cycle();
    end
    drive(1'b0, '0, 4'b1111); cycle();
    chk("stream_empty", down_valid, 4'b0000);

    // Channel 1 stuck holding 0xAA with ptr at 1
    do_reset();
    drive(1'b1, 8'h01, 4'b1101); cycle();
    drive(1'b1, 8'hAA, 4'b1101); cycle();
    drive(1'b1, 8'h03, 4'b1101); cycle();
    drive(1'b1, 8'h04, 4'b1101); cycle();
    drive(1'b1, 8'h05, 4'b1101); cycle();
    chk("stuck_ptr", dut.ptr_q, 2'd1);
    chk("stuck_hold", down_data[15:8], 8'hAA);
    drive(1'b1, 8'hBB, 4'b1101);
`ifdef ROUND_ROBIN_DEMUX_SKIP_EN
    chk("skip_ready", up_ready, 1'b1);
    cycle();
    chk("skip_ptr", dut.ptr_q, 2'd3);
    chk("skip_ch2", down_data[23:16], 8'hBB);
`else
    for (int k = 0; k < 4; k++) begin
      chk("stuck_stall", up_ready, 1'b0);
      cycle();
    end
    chk("stuck_ptr_held", dut.ptr_q, 2'd1);
`endif
    drive(1'b0, '0, 4'b1111); cycle();
    cycle();

    // Reset mid-operation with a word presented
    do_reset();
    drive(1'b1, 8'h61, 4'b0000); cycle();
    drive(1'b1, 8'h62, 4'b0000); cycle();
    drive(1'b1, 8'h63, 4'b0000); cycle();
    chk("pre_rst_valid", down_valid, 4'b0111);
    rst = 1'b1;
    drive(1'b1, 8'h77, 4'b0000); cycle();
    rst = 1'b0;
    drive(1'b0, '0, 4'b0000);
    chk("mid_rst_valid", down_valid, 4'b0000);
    chk("mid_rst_ptr", dut.ptr_q, 2'd0);
    chk("mid_rst_data", down_data, '0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
